regfile_wb_arb: RTL and testbench

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

---
 rtl/regfile_wb_arb_pkg.sv | 20 ++
 rtl/regfile_wb_arb_rr_arb3.sv | 34 +++
 rtl/regfile_wb_arb.sv | 112 +++++++++++
 tb/tb_regfile_wb_arb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arb_pkg.sv
// Shared definitions for the writeback arbiter: bus widths, requester
// indices and the round-robin pointer advance helper.
package regfile_wb_arb_pkg;

    localparam int REG_ADDR_BUS = 5;
    localparam int REG_DATA_BUS = 32;
    localparam int NUM_REQ      = 3;

    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_LSU = 2'd1,
        REQ_MDU = 2'd2
    } req_idx_e;

    // Successor of a requester index in round-robin order (mod 3).
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/regfile_wb_arb_rr_arb3.sv
// Three-way round-robin arbiter: the pointer names the highest-priority
// requester, the grant is one-hot (or zero when nothing is requested).
module rr_arb3
    import regfile_wb_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant
);

    function automatic logic [NUM_REQ-1:0] pick(
        input logic [NUM_REQ-1:0] r,
        input req_idx_e           a,
        input req_idx_e           b,
        input req_idx_e           c
    );
        logic [NUM_REQ-1:0] g;
        g = '0;
        if (r[a])      g[a] = 1'b1;
        else if (r[b]) g[b] = 1'b1;
        else if (r[c]) g[c] = 1'b1;
        return g;
    endfunction

    always_comb begin
        grant = '0;
        case (ptr)
            2'd1:    grant = pick(req, REQ_LSU, REQ_MDU, REQ_ALU);
            2'd2:    grant = pick(req, REQ_MDU, REQ_ALU, REQ_LSU);
            default: grant = pick(req, REQ_ALU, REQ_LSU, REQ_MDU);
        endcase
    end

endmodule

// File: rtl/regfile_wb_arb.sv
// Writeback arbiter: round-robin selects one of ALU/LSU/MDU per cycle into a
// registered regfile write port, and tracks pending destinations in a scoreboard.
module regfile_wb_arb
    import regfile_wb_arb_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_BUS,
    parameter int DATA_W = REG_DATA_BUS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            iss_valid,
    input  logic [ADDR_W-1:0]               iss_addr,
    input  logic                            flush,
    input  logic [ADDR_W-1:0]               chk_addr1,
    input  logic [ADDR_W-1:0]               chk_addr2,
    output logic                            busy1,
    output logic                            busy2,
    output logic                            we,
    output logic [ADDR_W-1:0]               waddr,
    output logic [DATA_W-1:0]               wdata
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [1:0]          ptr_reg;
    logic [1:0]          ptr_next;
    logic [NUM_REQ-1:0]  grant;
    logic                granted;
    logic [1:0]          g_idx;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_data;
    logic                write_en;
    logic                we_reg;
    logic [ADDR_W-1:0]   waddr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;

    rr_arb3 u_arb (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .grant (grant)
    );

    // No handshake may complete while reset is held.
    assign req_ready = rst_n ? '0 : grant;
    assign granted   = |req_ready;

    always_comb begin
        g_idx  = 2'd0;
        g_addr = '0;
        g_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                g_idx  = 2'(k);
                g_addr = req_addr[k];
                g_data = req_data[k];
            end
        end
    end

    assign ptr_next = granted ? next_idx(g_idx) : ptr_reg;
    // Writes to x0 are accepted from the requester but never reach the regfile.
    assign write_en = granted && (g_addr != '0);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ptr_reg   <= 2'd0;
            we_reg    <= 1'b0;
            waddr_reg <= '0;
            wdata_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
            we_reg  <= write_en;
            if (write_en) begin
                waddr_reg <= g_addr;
                wdata_reg <= g_data;
            end
        end
    end

    assign we    = we_reg;
    assign waddr = waddr_reg;
    assign wdata = wdata_reg;

    // Per-register priority: flush beats a new issue, which beats a retiring write.
    assign busy_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
            assign busy_next[gi] = flush                                        ? 1'b0 :
                                   (iss_valid && iss_addr == ADDR_W'(gi))       ? 1'b1 :
                                   (write_en  && g_addr   == ADDR_W'(gi))       ? 1'b0 :
                                                                                  busy_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy1 = busy_reg[chk_addr1];
    assign busy2 = busy_reg[chk_addr2];

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb: a cycle-level reference model is checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_regfile_wb_arb;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 1 << ADDR_W;

    logic                      clk;
    logic                      rst_n;
    logic [2:0]                req_valid;
    logic [2:0][ADDR_W-1:0]    req_addr;
    logic [2:0][DATA_W-1:0]    req_data;
    logic [2:0]                req_ready;
    logic                      iss_valid;
    logic [ADDR_W-1:0]         iss_addr;
    logic                      flush;
    logic [ADDR_W-1:0]         chk_addr1;
    logic [ADDR_W-1:0]         chk_addr2;
    logic                      busy1;
    logic                      busy2;
    logic                      we;
    logic [ADDR_W-1:0]         waddr;
    logic [DATA_W-1:0]         wdata;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .flush     (flush),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .busy1     (busy1),
        .busy2     (busy2),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int               m_ptr;
    bit               m_we;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;
    bit [NREG-1:0]    m_busy;
    bit               m_live = 1'b0;

    int               m_win;
    logic [ADDR_W-1:0] m_gaddr;
    logic [DATA_W-1:0] m_gdata;
    bit [NREG-1:0]    m_busy_nxt;

    function automatic int winner(input logic [2:0] v, input int p);
        for (int k = 0; k < 3; k++) begin
            if (v[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    always_comb begin
        m_win      = winner(req_valid, m_ptr);
        m_gaddr    = '0;
        m_gdata    = '0;
        m_busy_nxt = m_busy;
        if (m_win >= 0) begin
            m_gaddr = req_addr[m_win];
            m_gdata = req_data[m_win];
            if (m_gaddr != 0) m_busy_nxt[m_gaddr] = 1'b0;
        end
        if (iss_valid && iss_addr != 0) m_busy_nxt[iss_addr] = 1'b1;
        if (flush) m_busy_nxt = '0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            m_ptr   <= 0;
            m_we    <= 1'b0;
            m_waddr <= '0;
            m_wdata <= '0;
            m_busy  <= '0;
            m_live  <= 1'b1;
        end else begin
            m_busy <= m_busy_nxt;
            if (m_win >= 0) begin
                m_ptr <= (m_win + 1) % 3;
                m_we  <= (m_gaddr != 0);
                if (m_gaddr != 0) begin
                    m_waddr <= m_gaddr;
                    m_wdata <= m_gdata;
                end
            end else begin
                m_we <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_ready", req_ready, (rst_n || m_win < 0) ? 32'd0 : (32'd1 << m_win));
            chk("model_we",    we,    m_we);
            chk("model_waddr", waddr, m_waddr);
            chk("model_wdata", wdata, m_wdata);
            chk("model_busy1", busy1, m_busy[chk_addr1]);
            chk("model_busy2", busy2, m_busy[chk_addr2]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
        chk_addr1 = '0; chk_addr2 = '0;
        tick(); tick();
        req_valid = 3'b111;
        neg();
        chk("rst_ready", req_ready, 0);
        chk("rst_we",    we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);

        // Check 1: continuous round-robin
        tick();
        rst_n = 1'b0;
        req_addr[0] = 5'd1; req_addr[1] = 5'd2; req_addr[2] = 5'd3;
        req_data[0] = 32'hA; req_data[1] = 32'hB; req_data[2] = 32'hC;
        neg(); chk("c1_ready0", req_ready, 3'b001);
        tick(); neg();
        chk("c1_ready1", req_ready, 3'b010); chk("c1_we0", we, 1);
        chk("c1_waddr0", waddr, 1); chk("c1_wdata0", wdata, 32'hA);
        tick(); neg();
        chk("c1_ready2", req_ready, 3'b100);
        chk("c1_waddr1", waddr, 2); chk("c1_wdata1", wdata, 32'hB);
        tick(); neg();
        chk("c1_ready3", req_ready, 3'b001);
        chk("c1_waddr2", waddr, 3); chk("c1_wdata2", wdata, 32'hC);
        tick(); req_valid = '0; neg();
        chk("c1_waddr3", waddr, 1); chk("c1_we3", we, 1);
        tick(); neg();
        chk("c1_idle_we", we, 0);

        // Check 2: issue x5, LSU retires it
        tick(); iss_valid = 1'b1; iss_addr = 5'd5; chk_addr1 = 5'd5;
        neg(); chk("c2_busy_pre", busy1, 0);
        tick(); iss_valid = 1'b0;
        neg(); chk("c2_busy_set", busy1, 1);
        tick(); req_valid = 3'b010; req_addr[1] = 5'd5; req_data[1] = 32'h1234;
        neg(); chk("c2_ready", req_ready, 3'b010);
        tick(); req_valid = '0;
        neg();
        chk("c2_we", we, 1); chk("c2_waddr", waddr, 5);
        chk("c2_wdata", wdata, 32'h1234); chk("c2_busy_clr", busy1, 0);

        // Check 3: set and clear of x7 in the same cycle
        tick(); iss_valid = 1'b1; iss_addr = 5'd7; chk_addr2 = 5'd7;
        req_valid = 3'b001; req_addr[0] = 5'd7; req_data[0] = 32'h77;
        neg(); chk("c3_ready", req_ready, 3'b001);
        tick(); iss_valid = 1'b0; req_valid = '0;
        neg(); chk("c3_busy7", busy2, 1); chk("c3_waddr", waddr, 7);

        // Check 4: write to x0 is consumed silently
        tick(); req_valid = 3'b001; req_addr[0] = 5'd0; req_data[0] = 32'hFFFF; chk_addr1 = 5'd0;
        neg(); chk("c4_ready", req_ready, 3'b001);
        tick(); req_valid = '0;
        neg(); chk("c4_we", we, 0); chk("c4_busy0", busy1, 0);

        // Check 5: flush coincident with MDU grant and an issue
        tick(); iss_valid = 1'b1; iss_addr = 5'd3; chk_addr1 = 5'd3; chk_addr2 = 5'd9;
        tick(); iss_addr = 5'd9;
        tick(); iss_valid = 1'b0;
        neg(); chk("c5_busy3", busy1, 1); chk("c5_busy9", busy2, 1);
        tick(); flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd3;
        req_valid = 3'b100; req_addr[2] = 5'd4; req_data[2] = 32'h44;
        neg(); chk("c5_ready", req_ready, 3'b100);
        tick(); flush = 1'b0; iss_valid = 1'b0; req_valid = '0;
        neg();
        chk("c5_busy3_clr", busy1, 0); chk("c5_busy9_clr", busy2, 0);
        chk("c5_we", we, 1); chk("c5_waddr", waddr, 4);

        // Check 6: reset in the cycle of a grant
        tick(); req_valid = 3'b001; req_addr[0] = 5'd6; req_data[0] = 32'h66;
        iss_valid = 1'b1; iss_addr = 5'd11; chk_addr1 = 5'd11;
        tick(); rst_n = 1'b1; iss_valid = 1'b0;
        req_valid = 3'b010; req_addr[1] = 5'd8; req_data[1] = 32'h88;
        neg(); chk("c6_ready_rst", req_ready, 0); chk("c6_busy11", busy1, 1);
        tick(); rst_n = 1'b0; req_valid = 3'b111;
        req_addr[0] = 5'd10; req_addr[1] = 5'd12; req_addr[2] = 5'd13;
        req_data[0] = 32'h10; req_data[1] = 32'h12; req_data[2] = 32'h13;
        neg();
        chk("c6_we", we, 0); chk("c6_busy_clr", busy1, 0);
        chk("c6_ready_ptr0", req_ready, 3'b001);
        tick(); req_valid = '0;
        neg(); chk("c6_we_after", we, 1); chk("c6_waddr_after", waddr, 10);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
